// File: rtl/dcf77_sync_ctrl_pkg.sv
// Shared types and constants for the DCF77 sync controller.
package dcf77_sync_ctrl_pkg;

    localparam int unsigned GAP_W    = 13;
    localparam int unsigned ERR_W    = 2;
    localparam int unsigned HO_MIN_W = 11;

    typedef logic [GAP_W-1:0] gap_t;
    typedef logic [7:0]       bcd_t;

    typedef enum logic [1:0] {
        UNLOCKED  = 2'd0,
        CANDIDATE = 2'd1,
        LOCKED    = 2'd2,
        HOLDOVER  = 2'd3
    } sync_state_t;

    // Decoded DCF77 date/time payload, all fields BCD.
    typedef struct packed {
        bcd_t year;
        bcd_t month;
        bcd_t day_of_week;
        bcd_t day;
        bcd_t hour;
        bcd_t minute;
    } date_time_t;

    localparam gap_t GAP_MIN       = 13'd5900;
    localparam gap_t GAP_MAX       = 13'd6100;
    localparam gap_t GAP_TIMEOUT   = 13'd6200;
    localparam gap_t TICKS_PER_MIN = 13'd6000;
    localparam gap_t GAP_SAT       = 13'd8191;

    localparam logic [ERR_W-1:0]    ERR_LIMIT  = 2'd3;
    localparam logic [HO_MIN_W-1:0] HO_MIN_SAT = 11'd2047;
    localparam bcd_t                BCD_59     = 8'h59;

    // BCD minute + 1, wrapping 59 -> 00.
    function automatic bcd_t bcd_min_inc(input bcd_t m);
        bcd_t r;
        if (m[3:0] == 4'd9) begin
            r[3:0] = 4'd0;
            r[7:4] = (m[7:4] >= 4'd5) ? 4'd0 : m[7:4] + 4'd1;
        end else begin
            r[7:4] = m[7:4];
            r[3:0] = m[3:0] + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dcf77_sync_ctrl_if.sv
// Date/time bus from the DCF77 decoder, held stable between minute markers.
interface if_date_time;
    import dcf77_sync_ctrl_pkg::*;

    date_time_t dt;

    modport master (output dt);
    modport slave  (input  dt);
endinterface

// File: rtl/dcf77_sync_ctrl_frame_check.sv
// Combinational plausibility test: new frame is the stored frame plus one minute,
// arriving with a marker spacing of one (possibly leap-second) minute.
module dcf77_frame_check
    import dcf77_sync_ctrl_pkg::*;
(
    input  date_time_t i_stored,
    input  date_time_t i_new,
    input  gap_t       i_gap,
    output logic       o_plausible_c
);

    logic w_gap_ok;
    logic w_min_ok;
    logic w_rest_ok;

    // Gap window, minute step, and unchanged upper fields unless the hour rolls.
    always_comb begin
        w_gap_ok  = (i_gap >= GAP_MIN) && (i_gap <= GAP_MAX);
        w_min_ok  = (i_new.minute == bcd_min_inc(i_stored.minute));
        w_rest_ok = (i_stored.minute == BCD_59) ||
                    ((i_new.hour        == i_stored.hour)        &&
                     (i_new.day         == i_stored.day)         &&
                     (i_new.day_of_week == i_stored.day_of_week) &&
                     (i_new.month       == i_stored.month)       &&
                     (i_new.year        == i_stored.year));
        o_plausible_c = w_gap_ok && w_min_ok && w_rest_ok;
    end

endmodule

// File: rtl/dcf77_sync_ctrl.sv
// DCF77 lock controller: qualifies decoded minute frames and issues one sync
// request per accepted frame to a free-running clock, with holdover tracking.
module dcf77_sync_ctrl
    import dcf77_sync_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                clk_en,
    input  logic                frame_valid,
    input  logic                frame_error,
    if_date_time.slave          dcf77,
    output logic                dcf77_sync,
    output logic                locked,
    output sync_state_t         state,
    output logic [HO_MIN_W-1:0] holdover_minutes
);

    sync_state_t         r_state,    w_state_n;
    gap_t                r_gap,      w_gap_n;
    logic [ERR_W-1:0]    r_err_cnt,  w_err_n;
    date_time_t          r_frame,    w_frame_n;
    logic                r_sync,     w_sync_n;
    logic                r_locked,   w_locked_n;
    gap_t                r_ho_ticks, w_ho_ticks_n;
    logic [HO_MIN_W-1:0] r_ho_min,   w_ho_min_n;
    logic                r_primed,   w_primed_n;

    logic             w_marker;
    logic             w_valid;
    logic             w_error;
    logic             w_plausible;
    logic             w_good;
    logic             w_timeout;
    logic             w_accept;
    gap_t             w_gap_inc;
    gap_t             w_ho_tick_inc;
    logic [ERR_W-1:0] w_err_inc;

    dcf77_frame_check u_check (
        .i_stored      (r_frame),
        .i_new         (dcf77.dt),
        .i_gap         (r_gap),
        .o_plausible_c (w_plausible)
    );

    // Marker decode; a simultaneous valid and error is treated as an error.
    assign w_marker      = frame_valid | frame_error;
    assign w_valid       = frame_valid & ~frame_error;
    assign w_error       = frame_error;
    assign w_good        = w_valid & w_plausible;
    assign w_gap_inc     = (r_gap == GAP_SAT) ? r_gap : r_gap + 13'd1;
    assign w_timeout     = ~w_marker && (w_gap_inc >= GAP_TIMEOUT);
    assign w_ho_tick_inc = r_ho_ticks + 13'd1;
    assign w_err_inc     = r_err_cnt + 2'd1;

    // Next-state and next-value logic; nothing changes without clk_en.
    always_comb begin
        w_state_n    = r_state;
        w_gap_n      = r_gap;
        w_err_n      = r_err_cnt;
        w_frame_n    = r_frame;
        w_sync_n     = r_sync;
        w_ho_ticks_n = r_ho_ticks;
        w_ho_min_n   = r_ho_min;
        w_primed_n   = r_primed;
        w_accept     = 1'b0;

        if (clk_en) begin
            w_sync_n = 1'b0;
            w_gap_n  = w_marker ? '0 : w_gap_inc;
            if (w_valid) begin
                w_frame_n = dcf77.dt;
            end

            // Minutes of holdover, counted only while already in HOLDOVER.
            if (r_state == HOLDOVER) begin
                if (w_ho_tick_inc == TICKS_PER_MIN) begin
                    w_ho_ticks_n = '0;
                    if (r_ho_min != HO_MIN_SAT) begin
                        w_ho_min_n = r_ho_min + 11'd1;
                    end
                end else begin
                    w_ho_ticks_n = w_ho_tick_inc;
                end
            end else begin
                w_ho_ticks_n = '0;
            end

            case (r_state)
                UNLOCKED: begin
                    if (w_valid) begin
                        w_state_n = CANDIDATE;
                    end
                end
                CANDIDATE: begin
                    if (w_good) begin
                        w_accept = 1'b1;
                    end else if (w_error || w_timeout) begin
                        w_state_n = UNLOCKED;
                    end
                end
                LOCKED: begin
                    if (w_good) begin
                        w_accept = 1'b1;
                    end else if (w_marker) begin
                        w_err_n = w_err_inc;
                        if (w_err_inc == ERR_LIMIT) begin
                            w_state_n  = HOLDOVER;
                            w_primed_n = 1'b0;
                        end
                    end else if (w_timeout) begin
                        w_state_n  = HOLDOVER;
                        w_primed_n = 1'b0;
                    end
                end
                HOLDOVER: begin
                    // A frame must first be captured inside holdover before relocking.
                    if (w_good && r_primed) begin
                        w_accept = 1'b1;
                    end else if (w_valid) begin
                        w_primed_n = 1'b1;
                    end
                end
                default: begin
                    w_state_n = UNLOCKED;
                end
            endcase

            if (w_accept) begin
                w_state_n  = LOCKED;
                w_sync_n   = 1'b1;
                w_err_n    = '0;
                w_ho_min_n = '0;
            end
        end

        w_locked_n = (w_state_n == LOCKED);
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= UNLOCKED;
            r_gap      <= '0;
            r_err_cnt  <= '0;
            r_frame    <= '0;
            r_sync     <= 1'b0;
            r_locked   <= 1'b0;
            r_ho_ticks <= '0;
            r_ho_min   <= '0;
            r_primed   <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_gap      <= w_gap_n;
            r_err_cnt  <= w_err_n;
            r_frame    <= w_frame_n;
            r_sync     <= w_sync_n;
            r_locked   <= w_locked_n;
            r_ho_ticks <= w_ho_ticks_n;
            r_ho_min   <= w_ho_min_n;
            r_primed   <= w_primed_n;
        end
    end

    assign dcf77_sync       = r_sync;
    assign locked           = r_locked;
    assign state            = r_state;
    assign holdover_minutes = r_ho_min;

endmodule

// File: tb/tb_dcf77_sync_ctrl.sv
// Directed bench for dcf77_sync_ctrl: lock, wrap, gap window, errors, timeout, reset.
module tb_dcf77_sync_ctrl;
    import dcf77_sync_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_en;
    logic        frame_valid;
    logic        frame_error;
    logic        dcf77_sync;
    logic        locked;
    sync_state_t state;
    logic [10:0] holdover_minutes;

    int errors = 0;
    int checks = 0;

    if_date_time dt_if ();

    dcf77_sync_ctrl dut (
        .clk              (clk),
        .reset            (reset),
        .clk_en           (clk_en),
        .frame_valid      (frame_valid),
        .frame_error      (frame_error),
        .dcf77            (dt_if.slave),
        .dcf77_sync       (dcf77_sync),
        .locked           (locked),
        .state            (state),
        .holdover_minutes (holdover_minutes)
    );

    always #20 clk = ~clk;

    task automatic set_time(input logic [7:0] h, input logic [7:0] m,
                            input logic [7:0] d, input logic [7:0] dow);
        dt_if.dt.year        = 8'h24;
        dt_if.dt.month       = 8'h06;
        dt_if.dt.day         = d;
        dt_if.dt.day_of_week = dow;
        dt_if.dt.hour        = h;
        dt_if.dt.minute      = m;
    endtask

    // One clk_en tick carrying the given marker flags; starts and ends on a negedge.
    task automatic tick(input logic v, input logic e);
        clk_en = 1'b1; frame_valid = v; frame_error = e;
        @(negedge clk);
        clk_en = 1'b0; frame_valid = 1'b0; frame_error = 1'b0;
    endtask

    task automatic idle(input int n);
        clk_en = 1'b1;
        repeat (n) @(negedge clk);
        clk_en = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (state !== UNLOCKED) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b want 0", locked); end
        checks++; if (dcf77_sync !== 1'b0) begin errors++; $display("FAIL reset_sync: got %b want 0", dcf77_sync); end
        checks++; if (holdover_minutes !== 11'd0) begin errors++; $display("FAIL reset_homin: got %0d want 0", holdover_minutes); end
        reset = 1'b0;
        @(negedge clk);
        // Markers without clk_en must be ignored.
        frame_valid = 1'b1;
        repeat (3) @(negedge clk);
        frame_valid = 1'b0;
        checks++; if (state !== UNLOCKED) begin errors++; $display("FAIL ignore_no_clken: got %0d want 0", state); end
    endtask

    task automatic test_lock();
        int pulses;
        set_time(8'h12, 8'h34, 8'h14, 8'h05);
        tick(1'b1, 1'b0);
        checks++; if (state !== CANDIDATE) begin errors++; $display("FAIL lock_first: got %0d want 1", state); end
        idle(6000);
        set_time(8'h12, 8'h35, 8'h14, 8'h05);
        tick(1'b1, 1'b0);
        checks++; if (state !== LOCKED) begin errors++; $display("FAIL lock_state: got %0d want 2", state); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_locked: got %b want 1", locked); end
        checks++; if (dcf77_sync !== 1'b1) begin errors++; $display("FAIL lock_sync_set: got %b want 1", dcf77_sync); end
        repeat (3) @(negedge clk);
        checks++; if (dcf77_sync !== 1'b1) begin errors++; $display("FAIL lock_sync_hold: got %b want 1", dcf77_sync); end
        idle(1);
        checks++; if (dcf77_sync !== 1'b0) begin errors++; $display("FAIL lock_sync_clear: got %b want 0", dcf77_sync); end
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            idle(1);
            if (dcf77_sync) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL lock_single_pulse: got %0d extra want 0", pulses); end
    endtask

    task automatic test_errors_holdover();
        tick(1'b0, 1'b1);
        tick(1'b0, 1'b1);
        checks++; if (state !== LOCKED) begin errors++; $display("FAIL err_two: got %0d want 2", state); end
        checks++; if (dcf77_sync !== 1'b0) begin errors++; $display("FAIL err_nosync: got %b want 0", dcf77_sync); end
        tick(1'b0, 1'b1);
        checks++; if (state !== HOLDOVER) begin errors++; $display("FAIL err_three: got %0d want 3", state); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL err_locked: got %b want 0", locked); end
        idle(11999);
        checks++; if (holdover_minutes !== 11'd1) begin errors++; $display("FAIL ho_min_11999: got %0d want 1", holdover_minutes); end
        idle(1);
        checks++; if (holdover_minutes !== 11'd2) begin errors++; $display("FAIL ho_min_12000: got %0d want 2", holdover_minutes); end
    endtask

    task automatic test_holdover_relock();
        set_time(8'h13, 8'h00, 8'h14, 8'h05);
        tick(1'b1, 1'b0);
        checks++; if (state !== HOLDOVER) begin errors++; $display("FAIL ho_first: got %0d want 3", state); end
        checks++; if (dcf77_sync !== 1'b0) begin errors++; $display("FAIL ho_first_sync: got %b want 0", dcf77_sync); end
        idle(6100);
        checks++; if (holdover_minutes !== 11'd3) begin errors++; $display("FAIL ho_min_3: got %0d want 3", holdover_minutes); end
        set_time(8'h13, 8'h01, 8'h14, 8'h05);
        tick(1'b1, 1'b0);
        checks++; if (state !== LOCKED) begin errors++; $display("FAIL relock_gap6100: got %0d want 2", state); end
        checks++; if (dcf77_sync !== 1'b1) begin errors++; $display("FAIL relock_sync: got %b want 1", dcf77_sync); end
        checks++; if (holdover_minutes !== 11'd0) begin errors++; $display("FAIL relock_homin: got %0d want 0", holdover_minutes); end
    endtask

    task automatic test_timeout();
        idle(3000);
        // Cycles without clk_en neither count gap nor see markers.
        frame_valid = 1'b1; frame_error = 1'b1;
        repeat (500) @(negedge clk);
        frame_valid = 1'b0; frame_error = 1'b0;
        idle(3199);
        checks++; if (state !== LOCKED) begin errors++; $display("FAIL timeout_6199: got %0d want 2", state); end
        idle(1);
        checks++; if (state !== HOLDOVER) begin errors++; $display("FAIL timeout_6200: got %0d want 3", state); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL timeout_locked: got %b want 0", locked); end
    endtask

    task automatic test_wrap_async_reset();
        do_reset();
        set_time(8'h23, 8'h59, 8'h14, 8'h03);
        tick(1'b1, 1'b0);
        idle(6000);
        set_time(8'h00, 8'h00, 8'h15, 8'h04);
        tick(1'b1, 1'b0);
        checks++; if (state !== LOCKED) begin errors++; $display("FAIL wrap_state: got %0d want 2", state); end
        checks++; if (dcf77_sync !== 1'b1) begin errors++; $display("FAIL wrap_sync: got %b want 1", dcf77_sync); end
        #5 reset = 1'b1;
        #1;
        checks++; if (dcf77_sync !== 1'b0) begin errors++; $display("FAIL async_sync: got %b want 0", dcf77_sync); end
        checks++; if (state !== UNLOCKED) begin errors++; $display("FAIL async_state: got %0d want 0", state); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL async_locked: got %b want 0", locked); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_bad_gap();
        set_time(8'h12, 8'h34, 8'h14, 8'h05);
        tick(1'b1, 1'b0);
        idle(5800);
        set_time(8'h12, 8'h35, 8'h14, 8'h05);
        tick(1'b1, 1'b0);
        checks++; if (state !== CANDIDATE) begin errors++; $display("FAIL badgap_state: got %0d want 1", state); end
        checks++; if (dcf77_sync !== 1'b0) begin errors++; $display("FAIL badgap_sync: got %b want 0", dcf77_sync); end
        idle(6000);
        set_time(8'h12, 8'h36, 8'h14, 8'h05);
        tick(1'b1, 1'b0);
        checks++; if (state !== LOCKED) begin errors++; $display("FAIL badgap_third: got %0d want 2", state); end
        checks++; if (dcf77_sync !== 1'b1) begin errors++; $display("FAIL badgap_sync3: got %b want 1", dcf77_sync); end
    endtask

    task automatic test_both_high();
        do_reset();
        tick(1'b1, 1'b0);
        checks++; if (state !== CANDIDATE) begin errors++; $display("FAIL both_pre: got %0d want 1", state); end
        tick(1'b1, 1'b1);
        checks++; if (state !== UNLOCKED) begin errors++; $display("FAIL both_is_error: got %0d want 0", state); end
    endtask

    initial begin
        reset = 1'b1; clk_en = 1'b0; frame_valid = 1'b0; frame_error = 1'b0;
        set_time(8'h00, 8'h00, 8'h01, 8'h01);
        repeat (2) @(negedge clk);
        test_reset();
        test_lock();
        test_errors_holdover();
        test_holdover_relock();
        test_timeout();
        test_wrap_async_reset();
        test_bad_gap();
        test_both_high();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dcf77_sync_ctrl.md
DCF77_SYNC_CTRL -- requirements
Module: dcf77_sync_ctrl

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-002 The port list SHALL be, clock and reset first:
- clk  input  1  system clock (24 MHz)
- reset  input  1  asynchronous, active-high reset
- clk_en  input  1  10 ms tick, one clk cycle wide
- frame_valid  input  1  decoder minute marker with good parity; meaningful only with clk_en
- frame_error  input  1  decoder minute marker with parity or framing error; meaningful only with clk_en
- dcf77  if_date_time (input)  -  decoded date and time, held stable by the decoder until the next marker
- dcf77_sync  output  1  sync request to the free-running clock
- locked  output  1  high iff state is LOCKED
- state  output  2  current sync_state_t
- holdover_minutes  output  11  whole minutes spent in HOLDOVER, saturating

Function
REQ-003 The block SHALL update all state only on clk cycles where clk_en=1.
REQ-004 The block SHALL implement states UNLOCKED, CANDIDATE, LOCKED and HOLDOVER.
REQ-005 gap SHALL be a 13-bit count of clk_en ticks since the last marker; it saturates at 8191 and clears on every frame_valid or frame_error.
REQ-006 A marker event SHALL be clk_en with frame_valid or frame_error; if both are high, the event counts as an error.
REQ-007 A frame SHALL be plausible iff all three hold:
- frame_valid is high and frame_error is low.
- gap is in 5900..6100 inclusive (the upper bound covers the leap-second minute).
- dcf77 equals the stored frame advanced one minute, as defined in REQ-008.
REQ-008 One-minute advance SHALL be defined as follows:
- minute = stored minute + 1 in BCD modulo 60.
- If the stored minute is not 59, hour, day, day_of_week, month and year must equal the stored values.
- If the stored minute is 59, only the minute=00 check applies.
REQ-009 Every valid frame SHALL overwrite the stored frame, whether or not it was plausible.
REQ-010 State transitions SHALL be:
- UNLOCKED --valid frame--> CANDIDATE.
- CANDIDATE --plausible--> LOCKED, with sync.
- CANDIDATE --implausible valid frame--> CANDIDATE, with the new frame stored.
- CANDIDATE --error, or gap reaching 6200--> UNLOCKED.
REQ-011 In LOCKED:
- A plausible frame issues a sync and clears err_cnt.
- An error, or an implausible valid frame, increments err_cnt (2 bits) and issues no sync.
- When err_cnt reaches 3, or gap reaches 6200, the block SHALL enter HOLDOVER.
REQ-012 In HOLDOVER:
- The first valid frame is stored.
- The next plausible frame issues a sync and enters LOCKED.
- HOLDOVER never returns to UNLOCKED.
REQ-013 dcf77_sync SHALL be registered:
- It is set on the clk_en cycle that accepts a frame.
- It is cleared on the next clk_en cycle.
- The downstream clock therefore samples it exactly once, 10 ms after the marker.
REQ-014 holdover_minutes behaviour SHALL be:
- It increments every 6000 clk_en ticks spent in HOLDOVER, saturating at 2047.
- It clears on entry to LOCKED.
- It holds its value in UNLOCKED and CANDIDATE.
REQ-015 err_cnt SHALL clear on entry to LOCKED.
REQ-016 frame_valid or frame_error without clk_en SHALL be ignored.

Reset
REQ-017 Reset SHALL force the following values:
- state=UNLOCKED, locked=0, dcf77_sync=0.
- holdover_minutes=0, gap=0, err_cnt=0.
- Stored frame all zero.
REQ-018 Reset asserted mid-operation, including while dcf77_sync=1, SHALL clear all of the above immediately and asynchronously.

Structure
REQ-019 Package types SHALL hold the following:
- sync_state_t as a 2-bit enum: UNLOCKED=0, CANDIDATE=1, LOCKED=2, HOLDOVER=3.
- Constants GAP_MIN=5900, GAP_MAX=6100, GAP_TIMEOUT=6200, TICKS_PER_MIN=6000, ERR_LIMIT=3.
- The existing bcd_t.
REQ-020 The plausibility comparison SHALL be one combinational sub-module, dcf77_frame_check:
- Inputs: stored frame, new frame, gap.
- Output: plausible.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Lock: valid 12:34, then valid 12:35 after 6000 ticks -> state LOCKED and a single dcf77_sync, 1 clk_en later.
- Wrap: stored 23:59, then new 00:00 with a changed day after 6000 ticks -> plausible, sync issued.
- Bad gap: second frame 12:35 after 5800 ticks -> stays CANDIDATE, no sync; third frame 12:36 after 6000 ticks -> LOCKED.
- Errors: while LOCKED, three consecutive frame_error events -> HOLDOVER; after 12000 further ticks, holdover_minutes=2.
- Timeout: while LOCKED, no markers for 6200 ticks -> HOLDOVER, locked=0.
- Reset: reset asserted while dcf77_sync=1 -> dcf77_sync=0 and state UNLOCKED, without waiting for a clk edge.
